// File: rtl/nios_avalon_st_error_expander.sv
// nios_avalon_st_error_expander
//   Avalon-ST pass-through stage that widens the single per-beat error bit
//   into a 6-bit error vector carrying framing and size diagnostics. A
//   two-entry skid (output register + skid register) keeps every output
//   registered and takes out_ready off the in_ready path.
//
//   out_error bits:
//     [0] in_error of this beat
//     [1] sticky OR of in_error over the current packet, this beat included
//     [2] missing SOP (beat arrived while no packet was open)
//     [3] missing EOP (SOP arrived while a packet was still open)
//     [4] oversize (beat count within the packet exceeds MAX_BEATS)
//     [5] bad empty (non-zero empty on a beat that is not EOP)
//
// Ports
//   clk, reset                     clock, synchronous active-high reset
//   in_ready/in_valid/in_data/in_error/in_startofpacket/in_endofpacket/
//   in_empty                       Avalon-ST sink
//   out_ready/out_valid/out_data/out_error/out_startofpacket/
//   out_endofpacket/out_empty      Avalon-ST source
//
// Framing FSM
//   state  | meaning
//   IDLE   | no packet open; the next beat starts a packet
//   IN_PKT | packet open; waiting for EOP
module nios_avalon_st_error_expander #(
  parameter int MAX_BEATS = 256
) (
  input  logic        clk,
  input  logic        reset,
  output logic        in_ready,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  input  logic        in_error,
  input  logic        in_startofpacket,
  input  logic        in_endofpacket,
  input  logic [1:0]  in_empty,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [5:0]  out_error,
  output logic        out_startofpacket,
  output logic        out_endofpacket,
  output logic [1:0]  out_empty
);

  typedef enum logic {IDLE, IN_PKT} state_t;

  localparam logic [15:0] MAX_B = 16'(MAX_BEATS);

  // Stored beat layout: {error[5:0], sop, eop, empty[1:0], data[31:0]}
  localparam int BW = 42;

  state_t          state, state_next;
  logic [15:0]     count, count_next;
  logic            sticky, sticky_next;
  logic [5:0]      err_new;
  logic            pkt_start;

  logic            accept;
  logic            load_out;
  logic            skid_valid, skid_valid_next;
  logic [BW-1:0]   in_beat, out_beat, skid_beat;

  assign accept   = in_valid && in_ready;
  // Output register may take a new beat when empty or draining this cycle.
  assign load_out = !out_valid || out_ready;

  // Framing, counter and sticky evaluation; only accepted beats move state.
  always_comb begin
    state_next  = state;
    count_next  = count;
    sticky_next = sticky;
    err_new     = '0;
    pkt_start   = (state == IDLE) || in_startofpacket;
    if (accept) begin
      if (pkt_start) begin
        count_next  = 16'd1;
        sticky_next = in_error;
      end else begin
        count_next  = (count == 16'hFFFF) ? count : count + 16'd1;
        sticky_next = sticky | in_error;
      end
      err_new[0] = in_error;
      err_new[1] = sticky_next;
      err_new[2] = (state == IDLE) && !in_startofpacket;
      err_new[3] = (state == IN_PKT) && in_startofpacket;
      err_new[4] = count_next > MAX_B;
      err_new[5] = (in_empty != 2'd0) && !in_endofpacket;
      // Every start/continue case collapses to: EOP closes, otherwise open.
      state_next = in_endofpacket ? IDLE : IN_PKT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      count  <= '0;
      sticky <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      sticky <= sticky_next;
    end
  end

  assign in_beat = {err_new, in_startofpacket, in_endofpacket, in_empty, in_data};

  // Skid never holds a beat across a cycle where the output register loads,
  // because in_ready is low whenever the skid is occupied.
  assign skid_valid_next = load_out ? 1'b0 : (skid_valid | accept);

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid  <= 1'b0;
      out_beat   <= '0;
      skid_valid <= 1'b0;
      skid_beat  <= '0;
      in_ready   <= 1'b0;
    end else begin
      if (load_out) begin
        if (skid_valid) begin
          out_beat  <= skid_beat;
          out_valid <= 1'b1;
        end else if (accept) begin
          out_beat  <= in_beat;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_beat <= in_beat;
      end
      skid_valid <= skid_valid_next;
      in_ready   <= !skid_valid_next;
    end
  end

  assign out_error         = out_beat[41:36];
  assign out_startofpacket = out_beat[35];
  assign out_endofpacket   = out_beat[34];
  assign out_empty         = out_beat[33:32];
  assign out_data          = out_beat[31:0];

endmodule

// File: tb/tb_nios_avalon_st_error_expander.sv
module tb_nios_avalon_st_error_expander;

  localparam int MAXB = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_ready;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_error;
  logic        in_startofpacket;
  logic        in_endofpacket;
  logic [1:0]  in_empty;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [5:0]  out_error;
  logic        out_startofpacket;
  logic        out_endofpacket;
  logic [1:0]  out_empty;

  always #5 clk = ~clk;

  nios_avalon_st_error_expander #(.MAX_BEATS(MAXB)) dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_error          (in_error),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .in_empty          (in_empty),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_error         (out_error),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty)
  );

  typedef struct {
    logic [31:0] d;
    logic        sop;
    logic        eop;
    logic [1:0]  emp;
    logic [5:0]  err;
    int          cyc;
  } beat_t;

  beat_t       exp_q[$];
  logic [5:0]  err_log[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          m_in_pkt;
  int          m_cnt;
  bit          m_sticky;
  bit          check_lat = 0;
  bit          accepted;
  bit          saw_block;
  bit          hold_v = 0;
  logic [41:0] hold;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference: each accepted beat either opens a packet (no packet open, or SOP)
  // or extends the open one; error flags follow from that classification.
  task automatic model_accept();
    beat_t b;
    bit    start;
    start = !m_in_pkt || in_startofpacket;
    if (start) begin
      m_cnt    = 1;
      m_sticky = in_error;
    end else begin
      m_cnt    = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      m_sticky = m_sticky | in_error;
    end
    b.d   = in_data;
    b.sop = in_startofpacket;
    b.eop = in_endofpacket;
    b.emp = in_empty;
    b.err = {(in_empty != 0) && !in_endofpacket,
             m_cnt > MAXB,
             m_in_pkt && in_startofpacket,
             !m_in_pkt && !in_startofpacket,
             m_sticky,
             in_error};
    b.cyc = cyc;
    m_in_pkt = !in_endofpacket;
    exp_q.push_back(b);
  endtask

  // One clock: observe handshakes at the falling edge, then advance.
  task automatic step();
    beat_t       e;
    logic [41:0] cur;
    @(negedge clk);
    accepted = 0;
    cur = {out_error, out_startofpacket, out_endofpacket, out_empty, out_data};
    if (reset) begin
      exp_q.delete();
      m_in_pkt = 0;
      m_cnt    = 0;
      m_sticky = 0;
      hold_v   = 0;
    end else begin
      if (hold_v) chk("stall_hold", 64'(cur), 64'(hold));
      hold_v = out_valid && !out_ready;
      hold   = cur;
      if (!in_ready) saw_block = 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_fields", {out_startofpacket, out_endofpacket, out_empty, out_data},
              {e.sop, e.eop, e.emp, e.d});
          chk("out_error", 64'(out_error), 64'(e.err));
          err_log.push_back(out_error);
          if (check_lat) chk("latency", 64'(cyc - e.cyc), 1);
        end
      end
      if (in_valid && in_ready) begin
        model_accept();
        accepted = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic er, input logic sop,
                      input logic eop, input logic [1:0] emp);
    in_valid         = 1;
    in_data          = d;
    in_error         = er;
    in_startofpacket = sop;
    in_endofpacket   = eop;
    in_empty         = emp;
    for (int i = 0; i < 50; i++) begin
      step();
      if (accepted) break;
    end
    if (!accepted) chk("accept_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; in_valid = 0; in_data = 0; in_error = 0;
    in_startofpacket = 0; in_endofpacket = 0; in_empty = 0; out_ready = 1;
    #1;
    idle(3);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_out_error", 64'(out_error), 0);
    chk("rst_framing", {out_startofpacket, out_endofpacket, out_empty}, 0);
    reset = 0;
    step();
    chk("post_rst_in_ready", 64'(in_ready), 1);

    // Clean 3-beat packet, one-cycle latency.
    err_log.delete();
    check_lat = 1;
    send(32'h11, 0, 1, 0, 0);
    send(32'h22, 0, 0, 0, 0);
    send(32'h33, 0, 0, 1, 2);
    idle(3);
    check_lat = 0;
    chk("p1_count", 64'(err_log.size()), 3);
    for (int i = 0; i < 3; i++) chk("p1_err_clean", 64'(err_log[i]), 0);

    // Error on middle beat: instantaneous + sticky.
    err_log.delete();
    send(32'h11, 0, 1, 0, 0);
    send(32'h22, 1, 0, 0, 0);
    send(32'h33, 0, 0, 1, 2);
    idle(3);
    chk("p2_err0", 64'(err_log[0]), 64'h00);
    chk("p2_err1", 64'(err_log[1]), 64'h03);
    chk("p2_err2", 64'(err_log[2]), 64'h02);

    // Missing SOP, then missing EOP.
    err_log.delete();
    send(32'hA, 0, 0, 0, 0);
    send(32'hB, 0, 1, 1, 0);
    idle(3);
    chk("missing_sop", 64'(err_log[0]), 64'h04);
    chk("missing_eop", 64'(err_log[1]), 64'h08);

    // Oversize: 6 beats with MAX_BEATS=4.
    err_log.delete();
    for (int i = 0; i < 6; i++) send(32'(i), 0, i == 0, i == 5, 0);
    idle(3);
    for (int i = 0; i < 6; i++) chk("oversize_bit", 64'(err_log[i][4]), (i >= 4) ? 1 : 0);

    // Stall with continuous input: skid must fill and throttle in_ready.
    saw_block = 0;
    out_ready = 0;
    in_valid  = 1;
    in_data = 32'hC0DE0000; in_error = 0; in_startofpacket = 1;
    in_endofpacket = 0; in_empty = 0;
    for (int i = 0; i < 7; i++) begin
      if (i == 3) out_ready = 1;
      step();
      if (accepted) begin
        in_data = in_data + 1;
        in_startofpacket = 0;
        in_endofpacket = (i >= 5);
      end
    end
    in_valid = 0;
    idle(4);
    chk("in_ready_fell", 64'(saw_block), 1);

    // Reset mid-packet with both registers full.
    out_ready = 0;
    send(32'hD0, 0, 1, 0, 0);
    send(32'hD1, 0, 0, 0, 0);
    step();
    chk("skid_full", 64'(in_ready), 0);
    reset = 1;
    step();
    chk("rst_mid_out_valid", 64'(out_valid), 0);
    reset = 0;
    out_ready = 1;
    step();
    err_log.delete();
    send(32'h55, 0, 0, 1, 0);
    idle(3);
    chk("post_rst_beats", 64'(err_log.size()), 1);
    chk("post_rst_missing_sop", 64'(err_log[0][2]), 1);

    // Randomized traffic with random backpressure and occasional reset.
    in_valid = 0;
    for (int i = 0; i < 3000; i++) begin
      if (!in_valid || accepted) begin
        in_valid         = ($urandom_range(0, 3) != 0);
        in_data          = $urandom;
        in_error         = ($urandom_range(0, 7) == 0);
        in_startofpacket = ($urandom_range(0, 3) == 0);
        in_endofpacket   = ($urandom_range(0, 3) == 0);
        in_empty         = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 499) == 0);
      step();
    end
    reset = 0;
    in_valid = 0;
    out_ready = 1;
    idle(5);
    chk("drain_empty", 64'(exp_q.size()), 0);
    chk("drain_out_valid", 64'(out_valid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nios_avalon_st_error_expander.md
NIOS_AVALON_ST_ERROR_EXPANDER -- requirements
Module: nios_avalon_st_error_expander

Interface
REQ-001 Parameter MAX_BEATS, default 256, maximum legal beats per packet (1..65534).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_ready  output  1  sink ready, registered.
REQ-005 in_valid  input  1  sink beat valid.
REQ-006 in_data  input  32  sink data.
REQ-007 in_error  input  1  sink per-beat error.
REQ-008 in_startofpacket  input  1  sink SOP.
REQ-009 in_endofpacket  input  1  sink EOP.
REQ-010 in_empty  input  2  sink empty symbols, meaningful on EOP only.
REQ-011 out_ready  input  1  source ready.
REQ-012 out_valid  output  1  source beat valid, registered.
REQ-013 out_data  output  32  source data, registered.
REQ-014 out_error  output  6  expanded error vector, registered.
REQ-015 out_startofpacket  output  1  source SOP, registered.
REQ-016 out_endofpacket  output  1  source EOP, registered.
REQ-017 out_empty  output  2  source empty, registered.

Function
REQ-018 Handshake: sink beat accepted when in_valid && in_ready; source beat transferred when out_valid && out_ready; out_* stable while out_valid && !out_ready.
REQ-019 Buffering: two-entry skid (output register + skid register); in_ready = !skid_full, registered; no combinational path from out_ready to in_ready.
REQ-020 Latency: accepted beat appears on out_valid the next cycle when the output register is empty or drained that cycle; otherwise held in skid, order preserved, no loss or duplication.
REQ-021 Throughput: one beat per cycle sustained while out_ready stays high.
REQ-022 data, SOP, EOP, empty pass through unchanged alongside their beat.
REQ-023 Framing FSM states IDLE, IN_PKT, evaluated per accepted beat.
REQ-024 IDLE + beat with SOP: new packet; -> IN_PKT, or stays IDLE if EOP same beat.
REQ-025 IDLE + beat without SOP: out_error[2] (missing SOP) set; beat starts a new packet; transitions as REQ-024.
REQ-026 IN_PKT + beat with SOP: out_error[3] (missing EOP) set; beat starts a new packet; stays IN_PKT, or -> IDLE if EOP.
REQ-027 IN_PKT + beat with EOP, no SOP: -> IDLE.
REQ-028 Beat counter 16 bits: 1 on packet-start beat, +1 per further accepted beat, saturates at 65535.
REQ-029 out_error[4] (oversize) set on every beat whose count > MAX_BEATS.
REQ-030 out_error[0] = in_error of the same beat.
REQ-031 out_error[1] (sticky) = OR of in_error over all beats of the current packet up to and including this beat; cleared at packet start.
REQ-032 out_error[5] (bad empty) set when in_empty != 0 on a beat without EOP.
REQ-033 Error bits computed at acceptance and stored with the beat; later out_ready stalls do not alter them.
REQ-034 No beat accepted while reset is high; FSM, counter and sticky do not change on unaccepted cycles.

Reset
REQ-035 While reset high at a clock edge: out_valid=0, in_ready=0, out_data=0, out_error=0, out_startofpacket=0, out_endofpacket=0, out_empty=0, skid empty, FSM=IDLE, counter=0, sticky=0.
REQ-036 First cycle after reset deasserts: in_ready=1.
REQ-037 Reset mid-packet discards both buffered beats; next beat is framed from IDLE.

Verification
REQ-038 3-beat packet data 0x11,0x22,0x33, SOP beat0, EOP beat2 empty=2, out_ready=1 -> same beats 1 cycle later, out_error=0 each, out_empty=2 on beat2.
REQ-039 Same packet, in_error=1 on beat1 only -> out_error 0x00, 0x03, 0x02.
REQ-040 Beat without SOP in IDLE, then SOP beat with no prior EOP -> out_error[2]=1 on first, out_error[3]=1 on second.
REQ-041 MAX_BEATS=4, 6-beat packet -> out_error[4]=1 on beats 5 and 6 only.
REQ-042 Continuous input, out_ready low 3 cycles -> in_ready falls after skid fills, no beat lost or duplicated, order kept, out_* stable while stalled.
REQ-043 Reset asserted mid-packet with skid full -> out_valid=0 next cycle; following non-SOP beat flags out_error[2].
